// File: rtl/alu_arb_pkg.sv
// Shared types and constants for the alu_arbiter block and its alu32 datapath.
package alu_arb_pkg;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned FUNC_W = 3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  typedef struct packed {
    logic [DATA_W-1:0] a;
    logic [DATA_W-1:0] b;
    logic [FUNC_W-1:0] f;
  } alu_op_t;

  localparam logic [FUNC_W-1:0] F_AND = 3'b000;
  localparam logic [FUNC_W-1:0] F_OR  = 3'b001;
  localparam logic [FUNC_W-1:0] F_ADD = 3'b010;
  localparam logic [FUNC_W-1:0] F_SUB = 3'b110;
  localparam logic [FUNC_W-1:0] F_SLT = 3'b111;

endpackage

// File: rtl/alu_arbiter_alu32.sv
// alu32: 32-bit combinational ALU. f[2] inverts B and injects a carry,
// f[1:0] selects AND / OR / SUM / set-on-sign. SLT is the sign bit of the
// difference (no overflow correction). Overflow is reported for the
// arithmetic codes (f[1]=1) only.
module alu32
  import alu_arb_pkg::*;
(
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic [FUNC_W-1:0] f,
  output logic [DATA_W-1:0] y_c,
  output logic              zero_c,
  output logic              ovf_c
);

  logic [DATA_W-1:0] b_eff;
  logic [DATA_W-1:0] sum;

  // Operand conditioning, adder, result select and flags
  always_comb begin
    b_eff  = (f[2] == F_SUB[2]) ? ~b : b;
    sum    = a + b_eff + DATA_W'(f[2]);
    y_c    = '0;
    unique case (f[1:0])
      F_AND[1:0]: y_c = a & b_eff;
      F_OR[1:0]:  y_c = a | b_eff;
      F_ADD[1:0]: y_c = sum;
      F_SLT[1:0]: y_c = DATA_W'(sum[DATA_W-1]);
      default:    y_c = '0;
    endcase
    zero_c = (y_c == '0);
    ovf_c  = f[1] & ~(a[DATA_W-1] ^ b_eff[DATA_W-1]) & (a[DATA_W-1] ^ sum[DATA_W-1]);
  end

endmodule

// File: rtl/alu_arbiter.sv
// alu_arbiter: round-robin sharing of one alu32 between two requesters.
// IDLE grants and latches an operation, EXEC captures the ALU result, RESP
// presents it to the owner until accepted.
// Optional feature macro: ALU_ARB_STATS_EN adds saturating grant/overflow
// counters on ports stat_grant0, stat_grant1, stat_ovf.
module alu_arbiter
  import alu_arb_pkg::*;
#(
  parameter int unsigned STAT_W = 16
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic [1:0]              req_valid,
  output logic [1:0]              req_ready,
  input  logic [1:0][DATA_W-1:0]  req_a,
  input  logic [1:0][DATA_W-1:0]  req_b,
  input  logic [1:0][FUNC_W-1:0]  req_f,
  output logic [1:0]              rsp_valid,
  input  logic [1:0]              rsp_ready,
  output logic [DATA_W-1:0]       rsp_y,
  output logic                    rsp_zero,
  output logic                    rsp_ovf
`ifdef ALU_ARB_STATS_EN
  ,
  output logic [STAT_W-1:0]       stat_grant0,
  output logic [STAT_W-1:0]       stat_grant1,
  output logic [STAT_W-1:0]       stat_ovf
`endif
);

  state_t            state;
  state_t            state_d;
  logic              last;
  logic              owner;
  alu_op_t           op;
  logic              accept;
  logic              gnt_idx;
  logic [DATA_W-1:0] alu_y;
  logic              alu_zero;
  logic              alu_ovf;

  // Width sanity for the statistics counters
  if (STAT_W == 0) begin : g_stat_w_check
    $error("alu_arbiter: STAT_W must be at least 1");
  end

  // Shared ALU, fed only from the operand register
  alu32 u_alu (
    .a      (op.a),
    .b      (op.b),
    .f      (op.f),
    .y_c    (alu_y),
    .zero_c (alu_zero),
    .ovf_c  (alu_ovf)
  );

  // Next-state, round-robin grant and request accept
  always_comb begin
    state_d   = state;
    req_ready = 2'b00;
    accept    = 1'b0;
    gnt_idx   = 1'b0;
    unique case (state)
      IDLE: begin
        if (reset_n && (req_valid != 2'b00)) begin
          gnt_idx   = (req_valid == 2'b11) ? ~last : req_valid[1];
          req_ready = 2'(2'b01 << gnt_idx);
          accept    = 1'b1;
          state_d   = EXEC;
        end
      end
      EXEC: state_d = RESP;
      RESP: if (rsp_ready[owner]) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State, arbitration history, operand and result registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      last      <= 1'b1;
      owner     <= 1'b0;
      op        <= '0;
      rsp_valid <= 2'b00;
      rsp_y     <= '0;
      rsp_zero  <= 1'b0;
      rsp_ovf   <= 1'b0;
    end else begin
      state <= state_d;
      if (accept) begin
        last  <= gnt_idx;
        owner <= gnt_idx;
        op    <= '{a: req_a[gnt_idx], b: req_b[gnt_idx], f: req_f[gnt_idx]};
      end
      if (state == EXEC) begin
        rsp_y    <= alu_y;
        rsp_zero <= alu_zero;
        rsp_ovf  <= alu_ovf;
      end
      rsp_valid <= (state_d == RESP) ? 2'(2'b01 << owner) : 2'b00;
    end
  end

`ifdef ALU_ARB_STATS_EN
  // Saturating per-port grant counts and overflow count
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stat_grant0 <= '0;
      stat_grant1 <= '0;
      stat_ovf    <= '0;
    end else begin
      if (accept && !gnt_idx && (stat_grant0 != '1)) stat_grant0 <= stat_grant0 + STAT_W'(1);
      if (accept &&  gnt_idx && (stat_grant1 != '1)) stat_grant1 <= stat_grant1 + STAT_W'(1);
      if ((state == EXEC) && alu_ovf && (stat_ovf != '1)) stat_ovf <= stat_ovf + STAT_W'(1);
    end
  end
`endif

endmodule

// File: tb/tb_alu_arbiter.sv
// Self-checking bench for alu_arbiter: directed scenarios then randomized
// traffic, checked against an arithmetic reference of the ALU and a
// round-robin grant model.
module tb_alu_arbiter;
  import alu_arb_pkg::*;

  localparam int unsigned SW = 16;
  localparam longint MAXS = 64'sd2147483647;
  localparam longint MINS = -64'sd2147483648;

  logic clk = 1'b0;
  logic reset_n;
  logic [1:0] req_valid, req_ready, rsp_valid, rsp_ready;
  logic [1:0][31:0] req_a, req_b;
  logic [1:0][2:0]  req_f;
  logic [31:0] rsp_y;
  logic rsp_zero, rsp_ovf;
`ifdef ALU_ARB_STATS_EN
  logic [SW-1:0] stat_grant0, stat_grant1, stat_ovf;
`endif

  int n_cmp = 0;
  int n_bad = 0;
  bit m_last;
  int unsigned m_g0, m_g1, m_ov;

  always #5 clk = ~clk;

  alu_arbiter #(.STAT_W(SW)) dut (
    .clk(clk), .reset_n(reset_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .req_f(req_f),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_y(rsp_y), .rsp_zero(rsp_zero), .rsp_ovf(rsp_ovf)
`ifdef ALU_ARB_STATS_EN
    , .stat_grant0(stat_grant0), .stat_grant1(stat_grant1), .stat_ovf(stat_ovf)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference ALU from signed arithmetic
  function automatic void ref_alu(input logic [31:0] a, input logic [31:0] b, input logic [2:0] f,
                                  output logic [31:0] y, output logic z, output logic o);
    longint sa, sb, w;
    logic [31:0] lo;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    w  = f[2] ? (sa - sb) : (sa + sb);
    lo = w[31:0];
    case (f)
      3'd0: y = a & b;
      3'd1: y = a | b;
      3'd4: y = a & ~b;
      3'd5: y = a | ~b;
      3'd2, 3'd6: y = lo;
      default: y = {31'b0, lo[31]};
    endcase
    z = (y == 32'd0);
    o = f[1] && ((w > MAXS) || (w < MINS));
  endfunction

  task automatic set_req(input int p, input logic [31:0] a, input logic [31:0] b, input logic [2:0] f);
    req_valid[p] = 1'b1;
    req_a[p] = a;
    req_b[p] = b;
    req_f[p] = f;
  endtask

  function automatic logic [31:0] rand_operand();
    case ($urandom_range(0, 4))
      0: return 32'h0000_0000;
      1: return 32'h7FFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'hFFFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  // Serve one request from IDLE: grant, EXEC, RESP (optionally stalled),
  // optionally re-raising the owner's request together with rsp_ready.
  task automatic serve(input int stall, input bit raise,
                       input logic [31:0] na, input logic [31:0] nb, input logic [2:0] nf);
    int g;
    logic [1:0] oh;
    logic [31:0] ey;
    logic ez, eo;
    g  = (req_valid == 2'b11) ? (m_last ? 0 : 1) : (req_valid[0] ? 0 : 1);
    oh = (g == 0) ? 2'b01 : 2'b10;
    ref_alu(req_a[g], req_b[g], req_f[g], ey, ez, eo);
    #2 chk("grant_req_ready", 32'(req_ready), 32'(oh));
    @(posedge clk); #1;
    req_valid[g] = 1'b0;
    m_last = (g == 1);
    if (g == 0) m_g0++; else m_g1++;
    if (eo) m_ov++;
    #1;
    chk("exec_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("exec_req_ready", 32'(req_ready), 32'd0);
    @(posedge clk); #1;
    chk("rsp_valid", 32'(rsp_valid), 32'(oh));
    chk("rsp_y", rsp_y, ey);
    chk("rsp_zero", 32'(rsp_zero), 32'(ez));
    chk("rsp_ovf", 32'(rsp_ovf), 32'(eo));
    rsp_ready = ~oh;
    for (int i = 0; i < stall; i++) begin
      @(posedge clk); #1;
      chk("stall_rsp_valid", 32'(rsp_valid), 32'(oh));
      chk("stall_rsp_y", rsp_y, ey);
      chk("stall_req_ready", 32'(req_ready), 32'd0);
    end
    rsp_ready = oh;
    if (raise) begin
      set_req(g, na, nb, nf);
      #1 chk("resp_new_req_ready", 32'(req_ready), 32'd0);
    end
    @(posedge clk); #1;
    rsp_ready = 2'b00;
    chk("rsp_done_valid", 32'(rsp_valid), 32'd0);
  endtask

  initial begin
    reset_n = 1'b0;
    req_valid = 2'b00; rsp_ready = 2'b00;
    req_a = '0; req_b = '0; req_f = '0;
    m_last = 1'b1; m_g0 = 0; m_g1 = 0; m_ov = 0;
    #1;
    chk("rst_req_ready", 32'(req_ready), 32'd0);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_rsp_y", rsp_y, 32'd0);
    chk("rst_flags", {30'd0, rsp_zero, rsp_ovf}, 32'd0);
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;

    // Both ports valid from reset: port 0 first; port 0 re-requests during its RESP
    set_req(0, 32'd3, 32'd3, F_SUB);
    set_req(1, 32'h0000_00F0, 32'h0000_000F, F_OR);
    serve(0, 1'b1, 32'hFF00_FF00, 32'h0FF0_0FF0, F_AND);
    serve(0, 1'b0, 32'd0, 32'd0, 3'd0);   // second contest: port 1
    serve(0, 1'b0, 32'd0, 32'd0, 3'd0);   // then port 0

    // Port 0 alone, ADD 5+7
    set_req(0, 32'd5, 32'd7, F_ADD);
    serve(0, 1'b0, 32'd0, 32'd0, 3'd0);

    // Port 1 ADD overflow
    set_req(1, 32'h7FFF_FFFF, 32'd1, F_ADD);
    serve(0, 1'b0, 32'd0, 32'd0, 3'd0);
`ifdef ALU_ARB_STATS_EN
    chk("stat_ovf_first", 32'(stat_ovf), 32'd1);
`endif

    // Held response with the other port waiting
    set_req(0, 32'hDEAD_BEEF, 32'h0F0F_0F0F, 3'b100);
    set_req(1, 32'h1234_5678, 32'h1111_1111, 3'b011);
    serve(5, 1'b0, 32'd0, 32'd0, 3'd0);
    serve(0, 1'b0, 32'd0, 32'd0, 3'd0);

    // SLT -1 < 1
    set_req(0, 32'hFFFF_FFFF, 32'd1, F_SLT);
    serve(0, 1'b0, 32'd0, 32'd0, 3'd0);

    // Reset during EXEC discards the operation
    set_req(1, 32'd10, 32'd20, F_ADD);
    #2 chk("pre_rst_grant", 32'(req_ready), 32'd2);
    @(posedge clk); #1;
    req_valid = 2'b00;
    #2 reset_n = 1'b0;
    req_valid = 2'b11;
    #1;
    chk("midrst_req_ready", 32'(req_ready), 32'd0);
    chk("midrst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("midrst_rsp_y", rsp_y, 32'd0);
    chk("midrst_flags", {30'd0, rsp_zero, rsp_ovf}, 32'd0);
    req_valid = 2'b00;
    @(posedge clk); #1;
    reset_n = 1'b1;
    m_last = 1'b1; m_g0 = 0; m_g1 = 0; m_ov = 0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      chk("post_rst_no_rsp", 32'(rsp_valid), 32'd0);
    end
`ifdef ALU_ARB_STATS_EN
    chk("post_rst_stat_g1", 32'(stat_grant1), 32'd0);
`endif
    set_req(1, 32'd9, 32'd9, F_SUB);
    serve(0, 1'b0, 32'd0, 32'd0, 3'd0);

    // Randomized traffic
    for (int i = 0; i < 40; i++) begin
      for (int p = 0; p < 2; p++)
        if (!req_valid[p] && ($urandom_range(0, 1) == 1))
          set_req(p, rand_operand(), rand_operand(), 3'($urandom_range(0, 7)));
      if (req_valid == 2'b00)
        set_req(int'($urandom_range(0, 1)), rand_operand(), rand_operand(), 3'($urandom_range(0, 7)));
      serve(int'($urandom_range(0, 2)), 1'b0, 32'd0, 32'd0, 3'd0);
    end
    while (req_valid != 2'b00) serve(0, 1'b0, 32'd0, 32'd0, 3'd0);

`ifdef ALU_ARB_STATS_EN
    chk("stat_grant0", 32'(stat_grant0), m_g0);
    chk("stat_grant1", 32'(stat_grant1), m_g1);
    chk("stat_ovf", 32'(stat_ovf), m_ov);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/alu_arbiter.md
# alu_arbiter

- Shares one `alu32` instance between two requesters.
- Each request carries operands A, B and a 3-bit function code F. The block arbitrates round-robin, latches the winning operation, evaluates it on the shared ALU and returns Y, Zero and Overflow to the issuing requester over a valid/ready response channel.
- Sits between the two datapath clients and the ALU. It is the only driver of the ALU inputs.

## Interface
Parameters:
- `STAT_W`, default 16: width of the statistics counters. Only used when `ALU_ARB_STATS_EN` is defined.

Ports:
- `clk`  in  1: single clock, rising edge.
- `reset_n`  in  1: reset, asynchronous, active-low.
- `req_valid`  in  2: per-port request valid.
- `req_ready`  out  2: per-port request accept.
- `req_a`  in  2×32: per-port operand A.
- `req_b`  in  2×32: per-port operand B.
- `req_f`  in  2×3: per-port function code, passed to the ALU unmodified.
- `rsp_valid`  out  2: one-hot; identifies the port that owns the current response.
- `rsp_ready`  in  2: per-port response accept.
- `rsp_y`  out  32: result, shared by both ports.
- `rsp_zero`  out  1: ALU Zero flag.
- `rsp_ovf`  out  1: ALU Overflow flag.
- `stat_grant0`, `stat_grant1`, `stat_ovf`  out  STAT_W each: present only with `ALU_ARB_STATS_EN`.

## Operation
- FSM with three states: IDLE, EXEC, RESP.
- IDLE:
  - If any `req_valid` is set, grant one port.
  - Assert `req_ready[g]` only for the granted port, in the same cycle. `req_ready` depends combinationally on `req_valid`.
  - On the handshake, latch A, B and F into the operand register and record `owner=g`. Go to EXEC.
- EXEC:
  - The ALU evaluates the latched operands.
  - Capture Y, Zero and Overflow into the result register. Go to RESP.
- RESP:
  - Drive `rsp_valid[owner]=1`.
  - Stay until `rsp_ready[owner]=1`, then go to IDLE.
  - `rsp_ready` on the non-owner port is ignored.
- Arbitration:
  - Round-robin through a `last` register, updated on every grant.
  - If both ports are valid, grant `~last`. If one is valid, grant it.
  - `last` resets to 1, so port 0 wins the first contest.
- Requester rules:
  - Hold `req_valid` and its data stable until accepted.
  - Do not make `valid` depend on `ready`.
- ALU use:
  - All eight F codes are legal and passed through unmodified, including 3'b011 and 3'b1x0.
  - Overflow is taken from the ALU exactly as the ALU produces it.
- No new request is accepted while in EXEC or RESP; `req_ready=0` in both states.

## Timing
- Reset values, every output:
  - `req_ready=0`, `rsp_valid=0`, `rsp_y=0`, `rsp_zero=0`, `rsp_ovf=0`.
  - State is IDLE, `last=1`, all counters 0.
- Latency: request accepted at cycle N → `rsp_valid` at N+2.
- Response back-to-back: response consumed at cycle M → a new grant is possible at M+1.
- Throughput: at most one operation per 3 cycles.
- Response outputs come straight from the result register. They are stable while `rsp_valid` is high.
- Reset asserted mid-operation: the in-flight operation is discarded and no response is produced. Outputs clear asynchronously.
- Simultaneous events in RESP:
  - New `req_valid` arriving together with `rsp_ready`: not granted that cycle; it is arbitrated in the next IDLE cycle.
  - A port may present a new request while its own response is still pending. It is served after its response completes.

## Configuration
- `ALU_ARB_STATS_EN` defined:
  - `stat_grant0` / `stat_grant1` increment on each accepted request of their port.
  - `stat_ovf` increments on each EXEC cycle whose Overflow is 1.
  - All three saturate at all-ones and reset to 0.
- Undefined: the stat ports and counters do not exist, and the remaining behaviour is identical.

## Structure
- Shared package `alu_arb_pkg`:
  - `state_t` enum (IDLE, EXEC, RESP).
  - `alu_op_t` struct {a[31:0], b[31:0], f[2:0]}.
  - Function-code constants: `F_AND=3'b000`, `F_OR=3'b001`, `F_ADD=3'b010`, `F_SUB=3'b110`, `F_SLT=3'b111`.
- One sub-module instance: the existing `alu32`, fed from the operand register.

## Test plan
- Port 0 only, ADD 5+7 → `rsp_valid=2'b01` at N+2, Y=12, Zero=0, Ovf=0.
- Both ports valid from reset, port 0 SUB 3-3, port 1 OR 0xF0|0x0F:
  - Port 0 served first: Y=0, Zero=1.
  - Then port 1: Y=0xFF.
  - A second concurrent pair is granted to port 1 first.
- Port 1 ADD 0x7FFFFFFF+1 → Y=0x80000000, Ovf=1. With `ALU_ARB_STATS_EN`, `stat_ovf=1`.
- `rsp_ready` held low 5 cycles:
  - `rsp_valid` and Y stay stable.
  - `req_ready` stays 0 despite the other port being valid.
- SLT 0xFFFFFFFF vs 1 (F=111) → Y=1. `reset_n` pulsed low during EXEC → no response, all outputs 0, next request served normally.
